// File: rtl/clock_digit_scanner_if.sv
// Display bus between the timekeeper and the digit scanner: the HH:MM digits
// and blink/colon controls flow in, and the multiplexed pin drive flows out.
// master = timekeeper/board side, slave = clock_digit_scanner.
interface clock_digit_scanner_if;
  logic [1:0] H1;
  logic [3:0] H2;
  logic [2:0] M1;
  logic [3:0] M2;
  logic       blink_h;
  logic       blink_m;
  logic       colon_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output H1, H2, M1, M2, blink_h, blink_m, colon_en,
                  input  an, seg, dp);
  modport slave  (input  H1, H2, M1, M2, blink_h, blink_m, colon_en,
                  output an, seg, dp);
endinterface

// File: rtl/clock_digit_scanner.sv
// Time-multiplexed 4-digit seven-segment driver for an HH:MM clock.
// Round-robin digit scan with an anti-ghosting blank at the start of every
// slot, field blinking during adjust, and the colon on digit 2's dp.
// All pin outputs are registered (1-cycle latency, active-low).
// Optional macro DISP_LZ_BLANK_EN: blank the hours-tens digit when it is 0.
module clock_digit_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int BLINK_DIV   = 25000000
) (
  input logic                 clk,
  input logic                 rst,
  clock_digit_scanner_if.slave dsp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [BW-1:0] B_LAST  = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [3:0] digit;
  logic [6:0] seg_dec;
  logic       ghost, fblank, lz_blank;

  // Refresh prescaler/digit index and the free-running blink phase
  always_comb begin
    pcnt_d  = pcnt_q + 1'b1;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (pcnt_q == P_LAST) begin
      pcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    if (bcnt_q == B_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  // Select the digit for the current slot and decode it to segments
  always_comb begin
    digit = 4'd0;
    case (idx_q)
      2'd0: digit = dsp.M2;
      2'd1: digit = {1'b0, dsp.M1};
      2'd2: digit = dsp.H2;
      2'd3: digit = {2'b00, dsp.H1};
      default: digit = 4'd0;
    endcase
    seg_dec = SEG_DASH;
    case (digit)
      4'd0: seg_dec = 7'b1000000;
      4'd1: seg_dec = 7'b1111001;
      4'd2: seg_dec = 7'b0100100;
      4'd3: seg_dec = 7'b0110000;
      4'd4: seg_dec = 7'b0011001;
      4'd5: seg_dec = 7'b0010010;
      4'd6: seg_dec = 7'b0000010;
      4'd7: seg_dec = 7'b1111000;
      4'd8: seg_dec = 7'b0000000;
      4'd9: seg_dec = 7'b0010000;
      default: seg_dec = SEG_DASH;
    endcase
  end

  // Pin drive: ghost blank overrides everything; field/leading-zero blanking
  // only kills segments so the anode duty cycle stays constant
  always_comb begin
    ghost    = (pcnt_q < P_BLANK);
    fblank   = ~phase_q & ((dsp.blink_h & idx_q[1]) | (dsp.blink_m & ~idx_q[1]));
`ifdef DISP_LZ_BLANK_EN
    lz_blank = (idx_q == 2'd3) && (dsp.H1 == 2'd0);
`else
    lz_blank = 1'b0;
`endif
    an_d  = ghost ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = (ghost | fblank | lz_blank) ? SEG_OFF : seg_dec;
    // colon ignores field blinking; it only follows the blink phase
    dp_d  = ~((idx_q == 2'd2) & ~ghost & dsp.colon_en & phase_q);
  end

  // State and output registers; reset aborts any slot in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q  <= '0;
      idx_q   <= 2'd0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      an_q    <= 4'b1111;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign dsp.an  = an_q;
  assign dsp.seg = seg_q;
  assign dsp.dp  = dp_q;

endmodule

// File: tb/tb_clock_digit_scanner.sv
// Scoreboard bench for clock_digit_scanner with a short refresh/blink setup.
module tb_clock_digit_scanner;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int BD = 16;

  logic gclk = 1'b0;
  logic rst  = 1'b0;
  always #5 gclk = ~gclk;

  clock_digit_scanner_if bus();

  clock_digit_scanner #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk (gclk),
    .rst (rst),
    .dsp (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [11:0] sbq[$];
  int m_p, m_i, m_b;
  bit m_ph;
  logic [6:0] segtab[16];
  logic [3:0] ean[16];
  logic [6:0] eseg[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_out();
    logic [3:0] a, d;
    logic [6:0] s;
    logic p;
    bit hour_slot;
    case (m_i)
      0: d = bus.M2;
      1: d = {1'b0, bus.M1};
      2: d = bus.H2;
      default: d = {2'b00, bus.H1};
    endcase
    hour_slot = (m_i >= 2);
    a = 4'b1111;
    a[m_i] = 1'b0;
    s = segtab[d];
    p = !(m_i == 2 && bus.colon_en && m_ph);
    if (!m_ph && ((hour_slot && bus.blink_h) || (!hour_slot && bus.blink_m))) s = 7'h7F;
`ifdef DISP_LZ_BLANK_EN
    if (m_i == 3 && bus.H1 == 2'd0) s = 7'h7F;
`endif
    if (m_p < BC) begin
      a = 4'b1111; s = 7'h7F; p = 1'b1;
    end
    return {a, s, p};
  endfunction

  task automatic model_reset();
    m_p = 0; m_i = 0; m_b = 0; m_ph = 1'b1;
  endtask

  // push expectation, clock once, advance model, then check the DUT output
  task automatic step(input string tag);
    logic [11:0] e;
    sbq.push_back(model_out());
    @(posedge gclk);
    if (m_p == RD - 1) begin m_p = 0; m_i = (m_i + 1) % 4; end else m_p++;
    if (m_b == BD - 1) begin m_b = 0; m_ph = !m_ph; end else m_b++;
    #1;
    if (sbq.size() == 0) chk({tag, "_empty"}, 32'd0, 32'd1);
    else begin
      e = sbq.pop_front();
      chk(tag, {bus.an, bus.seg, bus.dp}, e);
    end
  endtask

  initial begin
    segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    ean  = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
             4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    eseg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    bus.H1 = 2'd1; bus.H2 = 4'd2; bus.M1 = 3'd3; bus.M2 = 4'd4;
    bus.blink_h = 1'b0; bus.blink_m = 1'b0; bus.colon_en = 1'b1;
    model_reset();

    // reset hold
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_dp", bus.dp, 1'b1);
    rst = 1'b1;

    // first scan against the fixed reference sequence
    for (int k = 0; k < 16; k++) begin
      step("scan");
      chk("scan_an", bus.an, ean[k]);
      if (k % 4 != 0) chk("scan_seg", bus.seg, eseg[k / 4]);
      else            chk("scan_ghost", bus.seg, 7'h7F);
    end

    // out-of-range minute digit shows a dash
    bus.M2 = 4'hC;
    for (int k = 0; k < 16; k++) begin
      step("dash");
      if (bus.an == 4'hE) chk("dash_seg", bus.seg, 7'b0111111);
    end
    bus.M2 = 4'd4;

    // minute pair blinking with the colon
    bus.blink_m = 1'b1;
    repeat (64) step("blink_m");

    // both pairs blinking, colon disabled
    bus.blink_h = 1'b1; bus.colon_en = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step("blink_hm");
      chk("nocolon_dp", bus.dp, 1'b1);
    end
    bus.blink_h = 1'b0; bus.blink_m = 1'b0; bus.colon_en = 1'b1;

    // hours tens zero: leading-zero behaviour depends on build option
    bus.H1 = 2'd0;
    for (int k = 0; k < 16; k++) begin
      step("lz");
`ifdef DISP_LZ_BLANK_EN
      if (bus.an == 4'h7) chk("lz_seg", bus.seg, 7'b1111111);
`else
      if (bus.an == 4'h7) chk("lz_seg", bus.seg, 7'b1000000);
`endif
    end
    bus.H1 = 2'd1;

    // mid-slot reset at idx=2, pcnt=2
    for (int k = 0; k < 16 && !(m_i == 2 && m_p == 2); k++) step("seek");
    chk("seek_reached", (m_i == 2 && m_p == 2), 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_an", bus.an, 4'hF);
    chk("mid_rst_seg", bus.seg, 7'h7F);
    chk("mid_rst_dp", bus.dp, 1'b1);
    model_reset();
    #1 rst = 1'b1;
    step("restart");
    chk("restart_ghost_an", bus.an, 4'hF);
    step("restart");
    chk("restart_an", bus.an, 4'hE);
    repeat (20) step("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
